// File: rtl/video_timing_pkg.sv
// Shared types for the video timing generator: mode encoding, per-mode
// timing record, the fixed mode table and the counter widths.
package video_timing_pkg;

  localparam int H_W = 12;
  localparam int V_W = 11;

  typedef enum logic [1:0] {
    MODE_720P  = 2'd0,
    MODE_480P  = 2'd1,
    MODE_1080P = 2'd2,
    MODE_RSVD  = 2'd3
  } mode_e;

  typedef struct packed {
    logic [H_W-1:0] h_active;
    logic [H_W-1:0] h_fp;
    logic [H_W-1:0] h_sync;
    logic [H_W-1:0] h_bp;
    logic [H_W-1:0] h_total;
    logic [V_W-1:0] v_active;
    logic [V_W-1:0] v_fp;
    logic [V_W-1:0] v_sync;
    logic [V_W-1:0] v_bp;
    logic [V_W-1:0] v_total;
  } timing_t;

  // Builds a timing record and derives the totals so they can never disagree
  // with the individual intervals.
  function automatic timing_t make_timing(int ha, int hf, int hs, int hb,
                                          int va, int vf, int vs, int vb);
    timing_t t;
    t.h_active = H_W'(ha);
    t.h_fp     = H_W'(hf);
    t.h_sync   = H_W'(hs);
    t.h_bp     = H_W'(hb);
    t.h_total  = H_W'(ha + hf + hs + hb);
    t.v_active = V_W'(va);
    t.v_fp     = V_W'(vf);
    t.v_sync   = V_W'(vs);
    t.v_bp     = V_W'(vb);
    t.v_total  = V_W'(va + vf + vs + vb);
    return t;
  endfunction

  // Index 0: 1280x720, 1: 640x480, 2: 1920x1080.
  localparam timing_t MODE_TABLE [3] = '{
    make_timing(1280, 110, 40, 220, 720, 5, 5, 20),
    make_timing(640, 16, 96, 48, 480, 10, 2, 33),
    make_timing(1920, 88, 44, 148, 1080, 4, 5, 36)
  };

endpackage

// File: rtl/video_mode_rom.sv
// Combinational mode -> timing lookup. The reserved mode falls back to 720p.
module video_mode_rom
  import video_timing_pkg::*;
(
  input  mode_e   mode,
  output timing_t timing
);

  // Table lookup; the default arm covers both 720p and the reserved code.
  always_comb begin
    case (mode)
      MODE_480P:  timing = MODE_TABLE[1];
      MODE_1080P: timing = MODE_TABLE[2];
      default:    timing = MODE_TABLE[0];
    endcase
  end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel/line counters plus registered sync, active,
// line-start, new-frame flags and a frame counter. Mode changes are taken
// only at the frame boundary.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int FC_W         = 6,
  parameter int DEFAULT_MODE = 0,
  parameter bit HS_POL       = 1'b1,
  parameter bit VS_POL       = 1'b1
) (
  input  logic            pixel_clk_in,
  input  logic            rst_in,
  input  logic [1:0]      mode_in,
  output logic [11:0]     hcount_out,
  output logic [10:0]     vcount_out,
  output logic            hs_out,
  output logic            vs_out,
  output logic            ad_out,
  output logic            ls_out,
  output logic            nf_out,
  output logic [FC_W-1:0] fc_out,
  output logic [1:0]      mode_out
);

  timing_t        tim;
  logic           running;
  logic           h_last;
  logic           v_last;
  logic [H_W-1:0] h_nxt;
  logic [V_W-1:0] v_nxt;
  logic [H_W-1:0] hs_lo;
  logic [H_W-1:0] hs_hi;
  logic [V_W-1:0] vs_lo;
  logic [V_W-1:0] vs_hi;
  logic           ad_nxt;
  logic           hs_nxt;
  logic           vs_nxt;
  logic           nf_nxt;

  video_mode_rom u_rom (
    .mode   (mode_e'(mode_out)),
    .timing (tim)
  );

  // Next raster position and the flags that describe it, so every registered
  // output lines up with the counters it is presented alongside.
  always_comb begin
    // NOTE: every signal driven here gets a value on every path, otherwise a latch is inferred.
    hs_lo  = tim.h_active + tim.h_fp;
    hs_hi  = hs_lo + tim.h_sync;
    vs_lo  = tim.v_active + tim.v_fp;
    vs_hi  = vs_lo + tim.v_sync;
    // >= rather than == keeps the counters inside the frame even if a
    // mode switch ever left them past the new totals.
    h_last = (hcount_out >= tim.h_total - 12'd1);
    v_last = (vcount_out >= tim.v_total - 11'd1);
    h_nxt  = hcount_out + 12'd1;
    v_nxt  = vcount_out;
    if (!running) begin
      // First edge after reset presents (0,0) rather than advancing past it.
      h_nxt = '0;
      v_nxt = '0;
    end else if (h_last) begin
      h_nxt = '0;
      v_nxt = v_last ? '0 : vcount_out + 11'd1;
    end
    // At the (0,0) that follows a mode switch these flags are the same for
    // every mode, so evaluating them with the outgoing table is exact.
    ad_nxt = (h_nxt < tim.h_active) && (v_nxt < tim.v_active);
    hs_nxt = (h_nxt >= hs_lo) && (h_nxt < hs_hi);
    vs_nxt = (v_nxt >= vs_lo) && (v_nxt < vs_hi);
    nf_nxt = (h_nxt == tim.h_active) && (v_nxt == tim.v_active);
  end

  // Counter, flag, frame-count and mode registers.
  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      running    <= 1'b0;
      hcount_out <= '0;
      vcount_out <= '0;
      hs_out     <= ~HS_POL;
      vs_out     <= ~VS_POL;
      ad_out     <= 1'b0;
      ls_out     <= 1'b0;
      nf_out     <= 1'b0;
      fc_out     <= '0;
      mode_out   <= 2'(DEFAULT_MODE);
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      running    <= 1'b1;
      hcount_out <= h_nxt;
      vcount_out <= v_nxt;
      hs_out     <= hs_nxt ? HS_POL : ~HS_POL;
      vs_out     <= vs_nxt ? VS_POL : ~VS_POL;
      ad_out     <= ad_nxt;
      ls_out     <= (h_nxt == '0);
      nf_out     <= nf_nxt;
      if (nf_nxt) begin
        fc_out <= fc_out + 1'b1;
      end
      // Mode is sampled only on the last pixel of the frame.
      if (running && h_last && v_last) begin
        mode_out <= mode_in;
      end
    end
  end

endmodule
